clock_min_sec_counter: RTL and testbench

- Minutes/seconds timebase for the 12-hour digital clock.
- Divides the system clock to a 1 Hz tick and counts seconds and minutes in BCD (00..59 each).
- Emits a one-cycle hour_en pulse on each 59:59→00:00 rollover. hour_en drives the enable input of the downstream mod-12 hour counter.
- Supports a validated time-set handshake.

---
 rtl/clock_min_sec_counter.sv | 112 +++++++++++
 tb/tb_clock_min_sec_counter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_min_sec_counter.sv
// Minutes/seconds timebase: divides clk to a 1 Hz advance, counts BCD
// seconds and minutes (00..59 each), and pulses hour_en on the 59:59 wrap.
// A validated load handshake (set_req -> set_ack / set_err) presets the time.
module clock_min_sec_counter #(
    parameter int unsigned CLK_DIV = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run_en,
    input  logic       set_req,
    input  logic [7:0] set_min,
    input  logic [7:0] set_sec,
    output logic       set_ack,
    output logic       set_err,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic       sec_tick,
    output logic       min_tick,
    output logic       hour_en
);

    localparam int unsigned   PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] presc;
    logic [PW-1:0] presc_next;
    logic [7:0]    sec_next;
    logic [7:0]    min_next;
    logic          load_ok;
    logic          load_bad;
    logic          terminal;
    logic          advance;
    logic          sec_wrap;
    logic          min_wrap;

    // A BCD field is legal for a 00..59 counter when tens <= 5 and ones <= 9.
    function automatic logic bcd59_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
    endfunction

    // Increment a legal 00..59 BCD value, wrapping 59 -> 00.
    function automatic logic [7:0] bcd59_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r[3:0] = '0;
            r[7:4] = (v[7:4] == 4'd5) ? '0 : v[7:4] + 4'd1;
        end else begin
            r[7:4] = v[7:4];
            r[3:0] = v[3:0] + 4'd1;
        end
        return r;
    endfunction

    // Load decode and advance qualification; an accepted load swallows the tick.
    always_comb begin
        load_ok  = set_req && bcd59_ok(set_min) && bcd59_ok(set_sec);
        load_bad = set_req && !(bcd59_ok(set_min) && bcd59_ok(set_sec));
        terminal = run_en && (presc == PRESC_LAST);
        advance  = terminal && !load_ok;
        sec_wrap = (sec_bcd == 8'h59);
        min_wrap = (min_bcd == 8'h59);
    end

    // Prescaler next value: load clears, running counts and wraps, else hold.
    always_comb begin
        presc_next = presc;
        if (load_ok) begin
            presc_next = '0;
        end else if (run_en) begin
            presc_next = terminal ? '0 : presc + PW'(1);
        end
    end

    // Counter next values: load has priority, then the ones/tens/carry chain.
    always_comb begin
        sec_next = sec_bcd;
        min_next = min_bcd;
        if (load_ok) begin
            sec_next = set_sec;
            min_next = set_min;
        end else if (advance) begin
            sec_next = bcd59_inc(sec_bcd);
            if (sec_wrap) begin
                min_next = bcd59_inc(min_bcd);
            end
        end
    end

    // State and registered pulses; pulses coincide with the first visible update.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc    <= '0;
            sec_bcd  <= '0;
            min_bcd  <= '0;
            set_ack  <= 1'b0;
            set_err  <= 1'b0;
            sec_tick <= 1'b0;
            min_tick <= 1'b0;
            hour_en  <= 1'b0;
        end else begin
            presc    <= presc_next;
            sec_bcd  <= sec_next;
            min_bcd  <= min_next;
            set_ack  <= load_ok;
            set_err  <= load_bad;
            sec_tick <= advance;
            min_tick <= advance && sec_wrap;
            hour_en  <= advance && sec_wrap && min_wrap;
        end
    end

endmodule

// File: tb/tb_clock_min_sec_counter.sv
// Self-checking bench for clock_min_sec_counter (CLK_DIV=4) against an
// arithmetic model that keeps time as total seconds 0..3599.
module tb_clock_min_sec_counter;

    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run_en = 1'b0;
    logic       set_req = 1'b0;
    logic [7:0] set_min = '0;
    logic [7:0] set_sec = '0;
    logic       set_ack, set_err, sec_tick, min_tick, hour_en;
    logic [7:0] sec_bcd, min_bcd;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model state
    int m_time  = 0;
    int m_presc = 0;
    bit m_ack, m_err, m_st, m_mt, m_he;

    clock_min_sec_counter #(.CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst(rst), .run_en(run_en), .set_req(set_req),
        .set_min(set_min), .set_sec(set_sec), .set_ack(set_ack),
        .set_err(set_err), .sec_bcd(sec_bcd), .min_bcd(min_bcd),
        .sec_tick(sec_tick), .min_tick(min_tick), .hour_en(hour_en)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    function automatic int from_bcd(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic bit field_ok(input logic [7:0] v);
        int t, o;
        t = int'(v) / 16;
        o = int'(v) % 16;
        return (t < 6) && (o < 10);
    endfunction

    // Expected outputs packed: ack, err, sec_tick, min_tick, hour_en, sec, min
    function automatic logic [20:0] expected();
        return {m_ack, m_err, m_st, m_mt, m_he, to_bcd(m_time % 60), to_bcd(m_time / 60)};
    endfunction

    function automatic logic [20:0] observed();
        return {set_ack, set_err, sec_tick, min_tick, hour_en, sec_bcd, min_bcd};
    endfunction

    // Advance one clock edge and apply the same inputs to the model.
    task automatic step();
        @(posedge clk);
        m_ack = 0; m_err = 0; m_st = 0; m_mt = 0; m_he = 0;
        if (rst) begin
            m_time  = 0;
            m_presc = 0;
        end else if (set_req && field_ok(set_min) && field_ok(set_sec)) begin
            m_time  = from_bcd(set_min) * 60 + from_bcd(set_sec);
            m_presc = 0;
            m_ack   = 1;
        end else begin
            m_err = set_req;
            if (run_en) begin
                if (m_presc == CLK_DIV - 1) begin
                    m_presc = 0;
                    m_time  = (m_time + 1) % 3600;
                    m_st    = 1;
                    m_mt    = (m_time % 60 == 0);
                    m_he    = (m_time == 0);
                end else begin
                    m_presc = m_presc + 1;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1; run_en = 1; set_req = 0;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if (observed() !== expected()) begin
                n_fails++;
                $display("FAIL reset: got %h expected %h", observed(), expected());
            end
        end
        rst = 0;
    endtask

    task automatic test_count();
        int st_cnt, mt_cnt, he_cnt;
        st_cnt = 0; mt_cnt = 0; he_cnt = 0;
        run_en = 1;
        for (int i = 0; i < 240; i++) begin
            step();
            st_cnt += sec_tick; mt_cnt += min_tick; he_cnt += hour_en;
            n_checks++;
            if (observed() !== expected()) begin
                n_fails++;
                $display("FAIL count cyc %0d: got %h expected %h", i, observed(), expected());
            end
        end
        n_checks++;
        if (st_cnt != 60 || mt_cnt != 1 || he_cnt != 0 || min_bcd !== 8'h01) begin
            n_fails++;
            $display("FAIL count_totals: sec_ticks %0d min_ticks %0d hour_en %0d min %h, expected 60 1 0 01",
                     st_cnt, mt_cnt, he_cnt, min_bcd);
        end
    endtask

    task automatic test_rollover();
        int he_cnt;
        he_cnt = 0;
        set_req = 1; set_min = 8'h59; set_sec = 8'h58;
        step();
        set_req = 0;
        n_checks++;
        if (observed() !== expected()) begin
            n_fails++;
            $display("FAIL rollover_load: got %h expected %h", observed(), expected());
        end
        for (int i = 0; i < 8; i++) begin
            step();
            he_cnt += hour_en;
            n_checks++;
            if (observed() !== expected()) begin
                n_fails++;
                $display("FAIL rollover cyc %0d: got %h expected %h", i, observed(), expected());
            end
        end
        n_checks++;
        if (he_cnt != 1 || {min_bcd, sec_bcd} !== 16'h0000) begin
            n_fails++;
            $display("FAIL rollover_hour: hour_en count %0d time %h, expected 1 and 0000", he_cnt, {min_bcd, sec_bcd});
        end
    endtask

    task automatic test_invalid();
        logic [15:0] bad [3];
        bad[0] = 16'h0560; bad[1] = 16'h055A; bad[2] = 16'h6F05;
        for (int k = 0; k < 3; k++) begin
            set_req = 1; set_min = bad[k][15:8]; set_sec = bad[k][7:0];
            step();
            set_req = 0;
            n_checks++;
            if (observed() !== expected() || set_err !== 1'b1) begin
                n_fails++;
                $display("FAIL invalid_%0d: got %h expected %h", k, observed(), expected());
            end
            for (int i = 0; i < 3; i++) begin
                step();
                n_checks++;
                if (observed() !== expected()) begin
                    n_fails++;
                    $display("FAIL invalid_follow_%0d: got %h expected %h", k, observed(), expected());
                end
            end
        end
    endtask

    task automatic test_load_on_terminal();
        set_req = 1; set_min = 8'h59; set_sec = 8'h59;
        step();
        set_req = 0;
        for (int i = 0; i < 3; i++) step();
        set_req = 1; set_min = 8'h12; set_sec = 8'h34;
        step();
        set_req = 0;
        n_checks++;
        if (observed() !== expected() || hour_en !== 1'b0 || set_ack !== 1'b1) begin
            n_fails++;
            $display("FAIL load_on_terminal: got %h expected %h", observed(), expected());
        end
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (observed() !== expected() || sec_tick !== (i == 3)) begin
                n_fails++;
                $display("FAIL load_on_terminal_follow %0d: got %h expected %h", i, observed(), expected());
            end
        end
    endtask

    task automatic test_pause();
        set_req = 1; set_min = 8'h00; set_sec = 8'h07;
        step();
        set_req = 0;
        step(); step();
        run_en = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++;
            if (observed() !== expected()) begin
                n_fails++;
                $display("FAIL pause cyc %0d: got %h expected %h", i, observed(), expected());
            end
        end
        run_en = 1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if (observed() !== expected() || sec_tick !== (i == 1)) begin
                n_fails++;
                $display("FAIL resume cyc %0d: got %h expected %h", i, observed(), expected());
            end
        end
        n_checks++;
        if (sec_bcd !== 8'h08) begin
            n_fails++;
            $display("FAIL resume_sec: got %h expected 08", sec_bcd);
        end
    endtask

    task automatic test_reset_priority();
        set_req = 1; set_min = 8'h45; set_sec = 8'h30;
        step();
        rst = 1; set_min = 8'h22; set_sec = 8'h11;
        step();
        rst = 0; set_req = 0;
        n_checks++;
        if (observed() !== 21'd0 || observed() !== expected()) begin
            n_fails++;
            $display("FAIL reset_priority: got %h expected 0", observed());
        end
        for (int i = 0; i < 8; i++) begin
            step();
            n_checks++;
            if (observed() !== expected()) begin
                n_fails++;
                $display("FAIL restart cyc %0d: got %h expected %h", i, observed(), expected());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 199) == 0);
            run_en  = ($urandom_range(0, 9) != 0);
            set_req = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 1) == 0) begin
                set_min = to_bcd($urandom_range(0, 59));
                set_sec = to_bcd($urandom_range(0, 59));
            end else begin
                set_min = 8'($urandom);
                set_sec = 8'($urandom);
            end
            step();
            n_checks++;
            if (observed() !== expected() || (set_ack && set_err)) begin
                n_fails++;
                $display("FAIL random cyc %0d: got %h expected %h", i, observed(), expected());
            end
        end
        rst = 0; set_req = 0; run_en = 1;
    endtask

    initial begin
        test_reset();
        test_count();
        test_rollover();
        test_invalid();
        test_load_on_terminal();
        test_pause();
        test_reset_priority();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
